fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined processor.
- Holds the program counter and drives the instruction-segment address of the unified memory; the memory returns the word combinationally on its instruction read port.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, flush, branch redirect, and a sticky fault when the PC leaves the instruction segment.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit words in the instruction segment; valid PCs are 0..IMEM_DEPTH-1.
- RESET_PC, 0, PC value loaded on reset (word address).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  hazard unit: replace IF/ID contents with a bubble.
- branch_taken  in  1  EX stage: redirect PC this cycle.
- branch_target  in  32  redirect word address.
- imem_addr  out  32  instruction word address to memory.
- imem_rdata  in  32  instruction word returned by memory, same cycle.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC of instr_d.
- pc_plus1_d  out  32  IF/ID pc_d+1.
- valid_d  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky: fetch attempted at PC >= IMEM_DEPTH.
- fetch_count  out  32  number of instructions captured into IF/ID since reset.

Behaviour:
- Addressing:
  - PC is a word address and increments by 1.
  - All arithmetic is 32-bit unsigned, wrap modulo 2^32.
- Reset (async assert, sync deassert at the next rising edge):
  - pc=RESET_PC, state=FETCH.
  - instr_d=0, pc_d=0, pc_plus1_d=0, valid_d=0.
  - fault=0, fetch_count=0.
  - Reset asserted mid-operation discards everything immediately.
- imem_addr:
  - = pc in FETCH; = 0 in HALTED (combinational from state/pc).
  - imem_rdata is used in the same cycle; fetch latency to IF/ID is 1 cycle.
- FSM states: FETCH, HALTED.
- FETCH, per rising edge, in priority order:
  1. branch_taken=1: pc<=branch_target; IF/ID<=bubble (instr 0, valid 0, pc_d/pc_plus1_d 0). Overrides stall and flush. No range check on the target.
  2. pc>=IMEM_DEPTH and stall=0: state<=HALTED, fault<=1, IF/ID<=bubble, pc holds.
  3. flush=1: IF/ID<=bubble.
     - stall=1: pc holds.
     - otherwise: pc<=pc+1 and the fetched word is discarded; fetch_count unchanged.
  4. stall=1: pc, IF/ID and fetch_count all hold.
  5. Otherwise: instr_d<=imem_rdata, pc_d<=pc, pc_plus1_d<=pc+1, valid_d<=1, pc<=pc+1, fetch_count<=fetch_count+1.
- HALTED:
  - Outputs hold the bubble; fault=1.
  - stall, flush and branch_taken are ignored.
  - Exit only via rst_n.
- Boundaries:
  - pc=IMEM_DEPTH-1 fetches normally; the next unstalled, non-redirected edge faults.
  - An out-of-range branch target loads, then faults on the following unstalled edge.
  - While stalled at an out-of-range PC: no fault until stall drops.
  - fetch_count wraps at 2^32.

Test Plan:
1. Reset then sequential fetch:
   - Stimulus: rst_n low 3 cycles then high; memory words 0..3 = 0xA0,0xA1,0xA2,0xA3; no hazards.
   - Required: imem_addr 0,1,2,3 on successive cycles; instr_d=0xA0 with pc_d=0, pc_plus1_d=1, valid_d=1 after first edge; fetch_count=4 after 4 edges.
2. Stall:
   - Stimulus: stall high 2 cycles at pc=2.
   - Required: imem_addr stays 2; instr_d/pc_d stay 0xA1/1; fetch_count frozen; on release, instr_d=0xA2, pc_d=2.
3. Branch with simultaneous stall and flush:
   - Stimulus: branch_taken=1, branch_target=10, stall=1, flush=1 at pc=3.
   - Required: next cycle imem_addr=10, valid_d=0, instr_d=0; following edge instr_d=mem[10], pc_d=10.
4. Flush alone:
   - Stimulus: flush=1 at pc=5.
   - Required: valid_d=0, pc advances to 6, fetch_count unchanged; next edge pc_d=6, valid_d=1.
5. Segment overrun:
   - Stimulus: run to pc=31 with IMEM_DEPTH=32.
   - Required: pc_d=31 captured; next edge fault=1, valid_d=0, imem_addr=0.
   - Then: branch_taken with target 0 ignored and fault stays 1 until rst_n pulse, after which pc=0 and fault=0.
6. Reset mid-operation:
   - Stimulus: assert rst_n low asynchronously between edges while valid_d=1, fetch_count=7.
   - Required: outputs clear immediately (valid_d=0, fetch_count=0, imem_addr=RESET_PC) without waiting for clk.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory port and IF/ID outputs.
// master is the fetch stage; slave is the surrounding pipeline and memory.
interface fetch_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus1_d;
    logic        valid_d;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, branch_taken, branch_target, imem_rdata,
        output imem_addr, instr_d, pc_d, pc_plus1_d, valid_d, fault, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, imem_rdata,
        input  imem_addr, instr_d, pc_d, pc_plus1_d, valid_d, fault, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: word-addressed PC, IF/ID register, stall/flush/redirect handling
// and a sticky halt when the PC leaves the instruction segment.
module fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
);
    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_d_q;
    logic [31:0] pc_plus1_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] count_q;
    logic        pc_out_of_range;

    assign pc_out_of_range = (pc_q >= IMEM_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_d_q     <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (bus.branch_taken) begin
                        // Redirect wins over stall and flush; target is range-checked on fetch.
                        pc_q       <= bus.branch_target;
                        instr_q    <= '0;
                        pc_d_q     <= '0;
                        pc_plus1_q <= '0;
                        valid_q    <= 1'b0;
                    end else if (pc_out_of_range && !bus.stall) begin
                        state_q    <= StHalted;
                        fault_q    <= 1'b1;
                        instr_q    <= '0;
                        pc_d_q     <= '0;
                        pc_plus1_q <= '0;
                        valid_q    <= 1'b0;
                    end else if (bus.flush) begin
                        instr_q    <= '0;
                        pc_d_q     <= '0;
                        pc_plus1_q <= '0;
                        valid_q    <= 1'b0;
                        if (!bus.stall) begin
                            pc_q <= pc_q + 32'd1;
                        end
                    end else if (!bus.stall) begin
                        instr_q    <= bus.imem_rdata;
                        pc_d_q     <= pc_q;
                        pc_plus1_q <= pc_q + 32'd1;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_q + 32'd1;
                        count_q    <= count_q + 32'd1;
                    end
                end
                StHalted: begin
                    // Only reset leaves this state.
                end
                default: state_q <= StHalted;
            endcase
        end
    end

    assign bus.imem_addr   = (state_q == StFetch) ? pc_q : 32'd0;
    assign bus.instr_d     = instr_q;
    assign bus.pc_d        = pc_d_q;
    assign bus.pc_plus1_d  = pc_plus1_q;
    assign bus.valid_d     = valid_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;
endmodule
